// File: rtl/coin_pulse_gen_if.sv
// coin_pulse_gen_if: coin-sensor inputs, busy handshake and conditioned
// coin outputs between the sensor front end and the vending FSM.
interface coin_pulse_gen_if;
  logic       coin1_raw;
  logic       coin5_raw;
  logic       busy;
  logic       p1;
  logic       p5;
  logic       reject;
  logic [7:0] credit_total;

  modport master (
    output coin1_raw, coin5_raw, busy,
    input  p1, p5, reject, credit_total
  );

  modport slave (
    input  coin1_raw, coin5_raw, busy,
    output p1, p5, reject, credit_total
  );
endinterface

// File: rtl/coin_pulse_gen.sv
// coin_pulse_gen: synchronizes and debounces the 1-peso and 5-peso coin
// sensors, arbitrates simultaneous coins, and keeps a saturating peso total.
// Optional feature macro COIN_REJECT_EN: when defined, coins arriving while
// busy or arriving together are rejected through the reject pulse; when
// undefined, busy is ignored, a simultaneous 5-peso coin wins, reject is 0.

// Per-channel 2-flop synchronizer plus debounce FSM; rise is combinational
// and marks the cycle in which the debounced level goes high.
module coin_pulse_gen_deb #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic rise
);
  typedef enum logic [1:0] {LOW, CHK_HI, HIGH, CHK_LO} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [1:0]       sync_q, sync_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s;

  assign s = sync_q[1];

  // Shift the raw sensor into the synchronizer chain
  always_comb begin
    sync_d = {sync_q[0], raw};
  end

  // Debounce next state: a new level must hold DEBOUNCE_CYCLES in a row
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise    = 1'b0;
    case (state_q)
      LOW: begin
        if (s) begin
          state_d = CHK_HI;
          cnt_d   = ONE;
        end
      end
      CHK_HI: begin
        if (!s) begin
          state_d = LOW;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = HIGH;
          cnt_d   = '0;
          rise    = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      HIGH: begin
        if (!s) begin
          state_d = CHK_LO;
          cnt_d   = ONE;
        end
      end
      CHK_LO: begin
        if (s) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
    endcase
  end

  // Synchronizer and FSM registers, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      state_q <= LOW;
      cnt_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

module coin_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic              clk,
  input  logic              reset,
  coin_pulse_gen_if.slave   bus
);
  logic [1:0] raw_v;
  logic [1:0] rise_v;

  // Channel 0 is the 1-peso sensor, channel 1 the 5-peso sensor
  assign raw_v = {bus.coin5_raw, bus.coin1_raw};

  for (genvar g = 0; g < 2; g++) begin : g_ch
    coin_pulse_gen_deb #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_deb (
      .clk  (clk),
      .reset(reset),
      .raw  (raw_v[g]),
      .rise (rise_v[g])
    );
  end

  logic       p1_q, p1_d;
  logic       p5_q, p5_d;
  logic       rej_q, rej_d;
  logic [7:0] total_q, total_d;
  logic [8:0] sum;

  // Arbitrate this cycle's rise events into at most one output pulse
  always_comb begin
    p1_d  = 1'b0;
    p5_d  = 1'b0;
    rej_d = 1'b0;
`ifdef COIN_REJECT_EN
    if (rise_v != 2'b00) begin
      if (bus.busy || (&rise_v)) begin
        rej_d = 1'b1;
      end else begin
        p1_d = rise_v[0];
        p5_d = rise_v[1];
      end
    end
`else
    p5_d = rise_v[1];
    p1_d = rise_v[0] & ~rise_v[1];
`endif
  end

`ifndef COIN_REJECT_EN
  logic unused_busy;
  assign unused_busy = bus.busy;
`endif

  // Running peso total, saturating at 255 instead of wrapping
  always_comb begin
    sum     = {1'b0, total_q} + (p5_d ? 9'd5 : 9'd0) + (p1_d ? 9'd1 : 9'd0);
    total_d = sum[8] ? 8'hFF : sum[7:0];
  end

  // Output registers; reset drops any pending pulse and clears the total
  always_ff @(posedge clk) begin
    if (reset) begin
      p1_q    <= 1'b0;
      p5_q    <= 1'b0;
      rej_q   <= 1'b0;
      total_q <= '0;
    end else begin
      p1_q    <= p1_d;
      p5_q    <= p5_d;
      rej_q   <= rej_d;
      total_q <= total_d;
    end
  end

  assign bus.p1           = p1_q;
  assign bus.p5           = p5_q;
  assign bus.reject       = rej_q;
  assign bus.credit_total = total_q;
endmodule

// File: doc/coin_pulse_gen.md
# coin_pulse_gen

Front-end conditioner for the 2-peso vending machine. It takes the raw, bouncy, asynchronous 1-peso and 5-peso coin-sensor lines and synchronizes and debounces them. It emits clean single-cycle `p1`/`p5` pulses that drive the vending FSM's coin inputs directly. It also arbitrates coins that arrive together, rejects coins while the vending FSM is busy, and keeps a running peso total for the display/audit logic.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive synchronized cycles a new level must hold before it is accepted. Legal range 2..255.
- `CNT_W`, default 8: width of the debounce counters. Must hold `DEBOUNCE_CYCLES-1`.

Ports:
- `clk`, input, 1: system clock.
- `reset`, input, 1: synchronous, active-high.
- `coin1_raw`, input, 1: asynchronous 1-peso sensor, high while a coin is present.
- `coin5_raw`, input, 1: asynchronous 5-peso sensor, high while a coin is present.
- `busy`, input, 1: high while the vending FSM is dispensing or returning change and cannot take coins.
- `p1`, output, 1: one-cycle pulse per accepted 1-peso coin.
- `p5`, output, 1: one-cycle pulse per accepted 5-peso coin.
- `reject`, output, 1: one-cycle pulse per rejected coin event; drives the coin-return gate.
- `credit_total`, output, 8: sum of accepted pesos, saturating at 255.

## Operation
- Each raw input passes through a 2-flop synchronizer (`s1`, `s5`), reset to 0.
- Each channel has a debounce FSM with states `LOW`, `CHK_HI`, `HIGH`, `CHK_LO`. The reset state is `LOW`, with debounced level `d=0` and counter 0.
  - In `LOW`: if `s=1`, go to `CHK_HI` with counter 1.
  - In `CHK_HI`: if `s=0`, return to `LOW` and clear the counter.
  - In `CHK_HI`: if `s=1` and counter = `DEBOUNCE_CYCLES-1`, go to `HIGH`, set `d=1` and raise a rise event. Otherwise increment the counter.
  - `HIGH` and `CHK_LO` mirror these rules for the falling direction. No event is raised on a fall.
- Arbitration uses this cycle's rise events `r1` and `r5`:
  - Only `r1`, `busy=0`: `p1=1`.
  - Only `r5`, `busy=0`: `p5=1`.
  - Any rise event with `busy=1`: `reject=1`, with no `p1`/`p5`.
  - `r1` and `r5` together: `reject=1`, with neither `p1` nor `p5` (with `COIN_REJECT_EN`, see Configuration).
- `reject` pulses once per cycle, even when both channels fire in that cycle.
- `credit_total` adds 1 on `p1` and 5 on `p5`. The sum saturates at 255 and never wraps. Only `reset` clears it.
- All outputs are registered. At most one of `p1`/`p5`/`reject` is high in any cycle.

## Timing
- Reset values: `p1=0`, `p5=0`, `reject=0`, `credit_total=0`, both FSMs in `LOW`, synchronizers 0.
- Latency example: raw goes high and is sampled at edge k, then held.
  - `s` is high after edge k+1.
  - `d` flips and `p1`/`p5`/`reject` rise at edge k+1+`DEBOUNCE_CYCLES`.
  - The pulse falls at the next edge.
  - `credit_total` updates on the same edge the pulse rises.
- A synchronized high lasting fewer than `DEBOUNCE_CYCLES` cycles produces no event. Bounces inside `CHK_HI` restart the count.
- A coin held high indefinitely produces exactly one pulse. The next coin needs a debounced low (`DEBOUNCE_CYCLES` cycles) first.
- `busy` is sampled in the same cycle as the rise event. There is no queuing: a rejected coin is never credited later.
- Reset asserted mid-debounce or mid-pulse:
  - At the next edge all state clears.
  - Any pending pulse is dropped.
  - A raw line still high after reset must re-qualify, giving a full latency of 2+`DEBOUNCE_CYCLES` edges.

## Configuration
- Macro: `COIN_REJECT_EN`.
- Defined:
  - `busy` gating and simultaneous-coin rejection operate as described above.
  - `reject` is live.
- Undefined:
  - `busy` is ignored.
  - On simultaneous events, `p5` is issued and the 1-peso event is dropped.
  - `reject` is tied to 0.
  - Debounce, latency and credit behaviour are unchanged.

## Test plan
- Reset release, then hold `coin1_raw` high from edge k (`DEBOUNCE_CYCLES=4`) -> `p1` high exactly in the cycle after edge k+5, `credit_total`=1, no second pulse while held.
- A 3-cycle glitch on `coin5_raw`, then a clean 10-cycle high -> no pulse for the glitch, one `p5`, `credit_total`=5.
- Both raw lines rise on the same edge -> with the macro: one `reject`, no `p1`/`p5`, total unchanged. Without the macro: one `p5`, total +5.
- Coin event with `busy=1` -> `reject` for one cycle, total unchanged. Same coin type after `busy` drops -> `p1`/`p5` accepted normally.
- 52 accepted 5-peso coins -> `credit_total` saturates at 255 and stays 255 after a further `p1`.
- Reset asserted at counter=2 in `CHK_HI` while raw stays high -> no pulse before reset. After release, pulse arrives at full latency (edge k'+5).
